// File: rtl/keypad_entry.sv
// keypad_entry: collects keypad digits into a card number and PIN and
// presents them as a single request on a valid/ready handshake.
module keypad_entry #(
  parameter int unsigned CARD_W     = 10,
  parameter int unsigned PIN_W      = 11,
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              key_ready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [CARD_W-1:0] req_card,
  output logic [PIN_W-1:0]  req_pin,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              field
);

  localparam int unsigned ACC_W  = (CARD_W > PIN_W) ? CARD_W : PIN_W;
  localparam int unsigned PROD_W = ACC_W + 4;
  localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT);

  localparam logic [PROD_W-1:0] CARD_MAX = PROD_W'((64'(1) << CARD_W) - 64'(1));
  localparam logic [PROD_W-1:0] PIN_MAX  = PROD_W'((64'(1) << PIN_W) - 64'(1));

  localparam logic [3:0] K_CLEAR  = 4'd10;
  localparam logic [3:0] K_ENTER  = 4'd11;
  localparam logic [3:0] K_CANCEL = 4'd12;

  localparam logic [1:0] E_OVF     = 2'b01;
  localparam logic [1:0] E_EMPTY   = 2'b10;
  localparam logic [1:0] E_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {S_CARD, S_PIN, S_PRESENT} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CARD_W-1:0]   card_q, card_d;
  logic                key_ready_q, key_ready_d;
  logic                req_valid_q, req_valid_d;
  logic [CARD_W-1:0]   req_card_q, req_card_d;
  logic [PIN_W-1:0]    req_pin_q, req_pin_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                field_q, field_d;

  logic                key_acc;
  logic                idle_active;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   field_max;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    tcnt_d     = tcnt_q;
    card_d     = card_q;
    req_card_d = req_card_q;
    req_pin_d  = req_pin_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    key_acc     = key_valid && key_ready_q;
    idle_active = (state_q == S_PIN) || ((state_q == S_CARD) && (dcnt_q != '0));
    prod        = PROD_W'(acc_q) * PROD_W'(10) + PROD_W'(key_code);
    field_max   = (state_q == S_CARD) ? CARD_MAX : PIN_MAX;

    case (state_q)
      S_CARD, S_PIN: begin
        if (key_acc) begin
          tcnt_d = '0;
          if (key_code <= 4'd9) begin
            if ((dcnt_q == DCNT_W'(MAX_DIGITS)) || (prod > field_max)) begin
              err_d      = 1'b1;
              err_code_d = E_OVF;
              acc_d      = '0;
              dcnt_d     = '0;
              card_d     = '0;
              state_d    = S_CARD;
            end else begin
              acc_d  = ACC_W'(prod);
              dcnt_d = dcnt_q + DCNT_W'(1);
            end
          end else if (key_code == K_CLEAR) begin
            acc_d  = '0;
            dcnt_d = '0;
          end else if (key_code == K_CANCEL) begin
            acc_d   = '0;
            dcnt_d  = '0;
            card_d  = '0;
            state_d = S_CARD;
          end else if (key_code == K_ENTER) begin
            if (dcnt_q == '0) begin
              err_d      = 1'b1;
              err_code_d = E_EMPTY;
            end else if (state_q == S_CARD) begin
              card_d  = CARD_W'(acc_q);
              acc_d   = '0;
              dcnt_d  = '0;
              state_d = S_PIN;
            end else begin
              req_pin_d  = PIN_W'(acc_q);
              req_card_d = card_q;
              state_d    = S_PRESENT;
            end
          end
          // codes 13-15 only restart the idle counter
        end else if (idle_active) begin
          if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            err_d      = 1'b1;
            err_code_d = E_TIMEOUT;
            tcnt_d     = '0;
            acc_d      = '0;
            dcnt_d     = '0;
            card_d     = '0;
            state_d    = S_CARD;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end else begin
          tcnt_d = '0;
        end
      end
      S_PRESENT: begin
        tcnt_d = '0;
        if (req_valid_q && req_ready) begin
          acc_d   = '0;
          dcnt_d  = '0;
          card_d  = '0;
          state_d = S_CARD;
        end
      end
      default: begin
        state_d = S_CARD;
        acc_d   = '0;
        dcnt_d  = '0;
        tcnt_d  = '0;
        card_d  = '0;
      end
    endcase

    key_ready_d = (state_d != S_PRESENT);
    req_valid_d = (state_d == S_PRESENT);
    field_d     = (state_d != S_CARD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CARD;
      acc_q       <= '0;
      dcnt_q      <= '0;
      tcnt_q      <= '0;
      card_q      <= '0;
      key_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      req_card_q  <= '0;
      req_pin_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      field_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      tcnt_q      <= tcnt_d;
      card_q      <= card_d;
      key_ready_q <= key_ready_d;
      req_valid_q <= req_valid_d;
      req_card_q  <= req_card_d;
      req_pin_q   <= req_pin_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      field_q     <= field_d;
    end
  end

  assign key_ready = key_ready_q;
  assign req_valid = req_valid_q;
  assign req_card  = req_card_q;
  assign req_pin   = req_pin_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign field     = field_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: scenario tasks plus a scoreboard monitor that
// pops expected errors and requests as the DUT produces them.
module tb_keypad_entry;

  localparam int unsigned TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_card;
  logic [10:0] req_pin;
  logic        err;
  logic [1:0]  err_code;
  logic        field;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_err[$];
  logic [9:0]  exp_card[$];
  logic [10:0] exp_pin[$];

  logic        rv_seen = 1'b0;
  logic [9:0]  cur_card;
  logic [10:0] cur_pin;
  logic [1:0]  e_code;

  keypad_entry #(.CARD_W(10), .PIN_W(11), .MAX_DIGITS(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .req_valid(req_valid), .req_ready(req_ready),
    .req_card(req_card), .req_pin(req_pin), .err(err), .err_code(err_code),
    .field(field)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: samples shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (err) begin
        n_checks++;
        if (exp_err.size() == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: err_code=%0d, required no error pulse", err_code);
        end else begin
          e_code = exp_err.pop_front();
          if (err_code !== e_code) begin
            n_fail++;
            $display("FAIL err_code: got %0d, required %0d", err_code, e_code);
          end
        end
      end
      if (req_valid) begin
        if (!rv_seen) begin
          rv_seen = 1'b1;
          if (exp_card.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: card=%0d pin=%0d, required no request", req_card, req_pin);
            cur_card = req_card;
            cur_pin  = req_pin;
          end else begin
            cur_card = exp_card.pop_front();
            cur_pin  = exp_pin.pop_front();
          end
        end
        n_checks++;
        if (req_card !== cur_card || req_pin !== cur_pin) begin
          n_fail++;
          $display("FAIL req_payload: card=%0d pin=%0d, required card=%0d pin=%0d",
                   req_card, req_pin, cur_card, cur_pin);
        end
      end else begin
        rv_seen = 1'b0;
      end
    end else begin
      rv_seen = 1'b0;
    end
  end

  // Present one key for one cycle; called and returns at a falling edge
  task automatic send_key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic push_req(input logic [9:0] c, input logic [10:0] p);
    exp_card.push_back(c);
    exp_pin.push_back(p);
  endtask

  task automatic accept_req();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (key_ready !== 1'b1 || req_valid !== 1'b0 || req_card !== 10'd0 || req_pin !== 11'd0 ||
        err !== 1'b0 || err_code !== 2'b00 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: kr=%b rv=%b card=%0d pin=%0d err=%b code=%0d field=%b, required 1 0 0 0 0 0 0",
               key_ready, req_valid, req_card, req_pin, err, err_code, field);
    end
  endtask

  task automatic test_full_request();
    send_key(1); send_key(0); send_key(2); send_key(3); send_key(11);
    n_checks++;
    if (field !== 1'b1 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL card_enter: field=%b key_ready=%b, required 1 1", field, key_ready);
    end
    send_key(1); send_key(1); send_key(0);
    push_req(10'd1023, 11'd1100);
    send_key(0); send_key(11);
    n_checks++;
    if (req_valid !== 1'b1 || key_ready !== 1'b0 || field !== 1'b1) begin
      n_fail++;
      $display("FAIL present: rv=%b kr=%b field=%b, required 1 0 1", req_valid, key_ready, field);
    end
    send_key(5); send_key(11);
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b1 || key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL present_hold: rv=%b kr=%b, required 1 0", req_valid, key_ready);
    end
    accept_req();
    n_checks++;
    if (req_valid !== 1'b0 || key_ready !== 1'b1 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: rv=%b kr=%b field=%b, required 0 1 0", req_valid, key_ready, field);
    end
    exp_err.push_back(2'b10);
    send_key(11);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b10) begin
      n_fail++;
      $display("FAIL keys_dropped_in_present: err=%b code=%0d, required 1 2", err, err_code);
    end
  endtask

  task automatic test_overflow();
    send_key(1); send_key(0); send_key(2);
    exp_err.push_back(2'b01);
    send_key(4);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL card_overflow: err=%b code=%0d field=%b, required 1 1 0", err, err_code, field);
    end
    send_key(9); send_key(11); send_key(8);
    push_req(10'd9, 11'd8);
    send_key(11);
    accept_req();
    send_key(1); send_key(11); send_key(2); send_key(0); send_key(4);
    exp_err.push_back(2'b01);
    send_key(8);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL pin_overflow_2048: err=%b code=%0d field=%b, required 1 1 0", err, err_code, field);
    end
    send_key(1); send_key(11); send_key(4); send_key(5); send_key(6);
    exp_err.push_back(2'b01);
    send_key(7);
    n_checks++;
    if (err !== 1'b1 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL pin_overflow_4567: err=%b field=%b, required 1 0", err, field);
    end
    send_key(1); send_key(11);
    for (int i = 0; i < 4; i++) send_key(1);
    n_checks++;
    if (err !== 1'b0 || field !== 1'b1) begin
      n_fail++;
      $display("FAIL four_digits_ok: err=%b field=%b, required 0 1", err, field);
    end
    exp_err.push_back(2'b01);
    send_key(1);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL fifth_digit: err=%b code=%0d field=%b, required 1 1 0", err, err_code, field);
    end
  endtask

  task automatic test_empty_enter();
    exp_err.push_back(2'b10);
    send_key(11);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_card: err=%b code=%0d field=%b, required 1 2 0", err, err_code, field);
    end
    send_key(3); send_key(11);
    exp_err.push_back(2'b10);
    send_key(11);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || field !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_pin: err=%b code=%0d field=%b, required 1 2 1", err, err_code, field);
    end
    send_key(4);
    push_req(10'd3, 11'd4);
    send_key(11);
    accept_req();
  endtask

  task automatic test_timeout();
    send_key(5); send_key(11);
    repeat (TIMEOUT - 1) @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || field !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: err=%b field=%b, required 0 1", err, field);
    end
    exp_err.push_back(2'b11);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || err_code !== 2'b11 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: err=%b code=%0d field=%b, required 1 3 0", err, err_code, field);
    end
    send_key(5); send_key(11);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_key(3);
    n_checks++;
    if (err !== 1'b0 || field !== 1'b1) begin
      n_fail++;
      $display("FAIL key_wins: err=%b field=%b, required 0 1", err, field);
    end
    send_key(12);
    n_checks++;
    if (err !== 1'b0 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel: err=%b field=%b, required 0 0", err, field);
    end
  endtask

  task automatic test_clear_cancel();
    send_key(1); send_key(2); send_key(11);
    send_key(3); send_key(10); send_key(9);
    push_req(10'd12, 11'd9);
    send_key(11);
    n_checks++;
    if (req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_req: rv=%b, required 1", req_valid);
    end
    accept_req();
    send_key(5); send_key(11); send_key(6); send_key(12);
    n_checks++;
    if (field !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_pin: field=%b err=%b, required 0 0", field, err);
    end
    send_key(7); send_key(11); send_key(1);
    push_req(10'd7, 11'd1);
    send_key(11);
    accept_req();
  endtask

  task automatic test_reset_present();
    send_key(4); send_key(11); send_key(2);
    push_req(10'd4, 11'd2);
    send_key(11);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_valid !== 1'b0 || key_ready !== 1'b1 || req_card !== 10'd0 || req_pin !== 11'd0 || field !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rv=%b kr=%b card=%0d pin=%0d field=%b, required 0 1 0 0 0",
               req_valid, key_ready, req_card, req_pin, field);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req_ready = 1'b1;
    send_key(1); send_key(14); send_key(5); send_key(11); send_key(4);
    push_req(10'd15, 11'd4);
    send_key(11);
    n_checks++;
    if (req_valid !== 1'b1 || req_card !== 10'd15) begin
      n_fail++;
      $display("FAIL b2b_first: rv=%b card=%0d, required 1 15", req_valid, req_card);
    end
    @(negedge clk);
    n_checks++;
    if (req_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release: rv=%b kr=%b, required 0 1", req_valid, key_ready);
    end
    send_key(8); send_key(11); send_key(9);
    push_req(10'd8, 11'd9);
    send_key(11);
    @(negedge clk);
    req_ready = 1'b0;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: rv=%b, required 0", req_valid);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_err.size() != 0 || exp_card.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d errors and %0d requests outstanding, required 0 0",
               name, exp_err.size(), exp_card.size());
      exp_err.delete();
      exp_card.delete();
      exp_pin.delete();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    req_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_full_request();   check_drained("full_request");
    test_overflow();       check_drained("overflow");
    test_empty_enter();    check_drained("empty_enter");
    test_timeout();        check_drained("timeout");
    test_clear_cancel();   check_drained("clear_cancel");
    test_reset_present();  check_drained("reset_present");
    test_back_to_back();   check_drained("back_to_back");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
